// File: rtl/conv_mac_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac_accum_if
//  Purpose  : Product-in / window-result-out bundle of the convolver MAC
//             accumulate stage.
//  Revision : 1.0
// ============================================================================
interface conv_mac_accum_if #(
    parameter int N = 32
) ();
    logic           i_clr;
    logic           i_valid;
    logic [2*N-1:0] i_product;
    logic           o_valid;
    logic [N-1:0]   o_result;
    logic           o_ovf;

    // master drives products (multiplier side), slave is the accumulator
    modport master (
        output i_clr,
        output i_valid,
        output i_product,
        input  o_valid,
        input  o_result,
        input  o_ovf
    );

    modport slave (
        input  i_clr,
        input  i_valid,
        input  i_product,
        output o_valid,
        output o_result,
        output o_ovf
    );
endinterface
`default_nettype wire

// File: rtl/conv_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac_accum
//  Purpose  : Sums KSIZE signed 2N-bit products per kernel window, rescales
//             the window sum to N-bit Q-format with saturation.
//  Revision : 1.0
// ============================================================================
module conv_mac_accum #(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int KSIZE = 9
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    conv_mac_accum_if.slave  bus
);
    localparam int c_ACC_W = 2*N + $clog2(KSIZE+1);
    localparam int c_EXT_W = c_ACC_W - 2*N;
    localparam int c_CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_TAP = c_CNT_W'(KSIZE-1);

    // Saturation bounds of the N-bit result, sign-extended to accumulator width
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [c_ACC_W-1:0] r_acc;
    logic        [c_CNT_W-1:0] r_tap_cnt;
    logic signed [c_ACC_W-1:0] r_sum;
    logic                      r_sum_vld;
    logic                      r_valid;
    logic        [N-1:0]       r_result;
    logic                      r_ovf;

    logic signed [c_ACC_W-1:0] w_ext;
    logic signed [c_ACC_W-1:0] w_win_sum;
    logic signed [c_ACC_W-1:0] w_sh;
    logic                      w_last;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic        [N-1:0]       w_rescaled;

    assign w_ext     = signed'({{c_EXT_W{bus.i_product[2*N-1]}}, bus.i_product});
    assign w_win_sum = r_acc + w_ext;
    assign w_last    = bus.i_valid && (r_tap_cnt == c_LAST_TAP);

    // Arithmetic shift floors toward -inf, dropping the extra Q fraction bits
    assign w_sh     = r_sum >>> Q;
    assign w_sat_hi = (w_sh > c_SAT_MAX);
    assign w_sat_lo = (w_sh < c_SAT_MIN);

    always_comb begin
        w_rescaled = w_sh[N-1:0];
        if (w_sat_hi) begin
            w_rescaled = c_SAT_MAX[N-1:0];
        end else if (w_sat_lo) begin
            w_rescaled = c_SAT_MIN[N-1:0];
        end
    end

    // Accumulate stage: the last tap moves the window sum to r_sum and
    // restarts the accumulator in the same edge, so windows may abut.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_tap_cnt <= '0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
        end else if (bus.i_clr) begin
            r_acc     <= '0;
            r_tap_cnt <= '0;
            r_sum_vld <= 1'b0;
        end else begin
            r_sum_vld <= w_last;
            if (w_last) begin
                r_sum     <= w_win_sum;
                r_acc     <= '0;
                r_tap_cnt <= '0;
            end else if (bus.i_valid) begin
                r_acc     <= w_win_sum;
                r_tap_cnt <= r_tap_cnt + 1'b1;
            end
        end
    end

    // Output stage: a clear also kills a sum completed on the previous edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (bus.i_clr) begin
            r_valid  <= 1'b0;
        end else begin
            r_valid <= r_sum_vld;
            if (r_sum_vld) begin
                r_result <= w_rescaled;
                r_ovf    <= w_sat_hi | w_sat_lo;
            end
        end
    end

    assign bus.o_valid  = r_valid;
    assign bus.o_result = r_result;
    assign bus.o_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_mac_accum
//  Purpose  : Directed + random checks of conv_mac_accum (N=16, Q=8, KSIZE=3)
//             against a window-queue reference model.
//  Revision : 1.0
// ============================================================================
module tb_conv_mac_accum;
    localparam int N     = 16;
    localparam int Q     = 8;
    localparam int KSIZE = 3;

    logic clk;
    logic rst_n;

    conv_mac_accum_if #(.N(N)) bus ();

    conv_mac_accum #(.N(N), .Q(Q), .KSIZE(KSIZE)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: taps of the open window, and a finished window
    // sum waiting one edge for the output stage.
    longint      win[$];
    bit          pend;
    longint      pend_sum;
    logic        exp_valid;
    logic [15:0] exp_result;
    logic        exp_ovf;

    logic [15:0] cap_res[$];
    logic        cap_ovf[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        pend       = 1'b0;
        pend_sum   = 0;
        exp_valid  = 1'b0;
        exp_result = '0;
        exp_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic clr, input logic vld, input logic [31:0] prod);
        longint sh;
        if (clr) begin
            win.delete();
            pend      = 1'b0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = pend;
            if (pend) begin
                sh = pend_sum >>> Q;
                if (sh > 32767) begin
                    exp_result = 16'h7FFF; exp_ovf = 1'b1;
                end else if (sh < -32768) begin
                    exp_result = 16'h8000; exp_ovf = 1'b1;
                end else begin
                    exp_result = sh[15:0]; exp_ovf = 1'b0;
                end
            end
            pend = 1'b0;
            if (vld) begin
                win.push_back(longint'($signed(prod)));
                if (win.size() == KSIZE) begin
                    pend_sum = 0;
                    foreach (win[i]) pend_sum += win[i];
                    pend = 1'b1;
                    win.delete();
                end
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".valid"},  32'(bus.o_valid),  32'(exp_valid));
        check({tag, ".result"}, 32'(bus.o_result), 32'(exp_result));
        check({tag, ".ovf"},    32'(bus.o_ovf),    32'(exp_ovf));
    endtask

    // One clock edge; entered and left at posedge+1
    task automatic step(input string tag, input logic clr, input logic vld, input logic [31:0] prod);
        bus.i_clr     = clr;
        bus.i_valid   = vld;
        bus.i_product = prod;
        @(posedge clk);
        #1;
        model_edge(clr, vld, prod);
        compare_outputs(tag);
        if (bus.o_valid === 1'b1) begin
            cap_res.push_back(bus.o_result);
            cap_ovf.push_back(bus.o_ovf);
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        compare_outputs({tag, ".held"});
        rst_n = 1'b1;
    endtask

    task automatic check_caps(input string tag, input int n, input logic [15:0] r0,
                              input logic o0, input logic [15:0] r1);
        check({tag, ".count"}, 32'(cap_res.size()), 32'(n));
        if (n >= 1 && cap_res.size() >= 1) begin
            check({tag, ".res0"}, 32'(cap_res[0]), 32'(r0));
            check({tag, ".ovf0"}, 32'(cap_ovf[0]), 32'(o0));
        end
        if (n >= 2 && cap_res.size() >= 2) begin
            check({tag, ".res1"}, 32'(cap_res[1]), 32'(r1));
        end
        cap_res.delete();
        cap_ovf.delete();
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] p;
        logic        v;
        logic        c;

        rst_n         = 1'b0;
        bus.i_clr     = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_product = '0;
        model_reset();
        #1;
        compare_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_outputs("reset2");
        rst_n = 1'b1;

        // Nominal window with explicit latency check
        step("t1.tap0", 1'b0, 1'b1, 32'h0001_0000);
        step("t1.tap1", 1'b0, 1'b1, 32'h0001_0000);
        step("t1.tap2", 1'b0, 1'b1, 32'h0001_0000);
        check("t1.no_early_strobe", 32'(bus.o_valid), 32'd0);
        step("t1.out", 1'b0, 1'b0, 32'h0);
        check("t1.strobe", 32'(bus.o_valid), 32'd1);
        check("t1.result", 32'(bus.o_result), 32'h0300);
        step("t1.after", 1'b0, 1'b0, 32'h0);
        check("t1.one_cycle", 32'(bus.o_valid), 32'd0);
        check("t1.hold", 32'(bus.o_result), 32'h0300);
        check_caps("t1", 1, 16'h0300, 1'b0, 16'h0);

        // Negative sum with floor truncation
        step("t2", 1'b0, 1'b1, 32'hFFFF_0000);
        step("t2", 1'b0, 1'b1, 32'hFFFF_0000);
        step("t2", 1'b0, 1'b1, 32'hFFFF_FF80);
        idle("t2", 2);
        check_caps("t2", 1, 16'hFDFF, 1'b0, 16'h0);

        // Positive then negative saturation, back-to-back windows
        for (int i = 0; i < 3; i++) step("t3p", 1'b0, 1'b1, 32'h3FFF_0000);
        for (int i = 0; i < 3; i++) step("t3n", 1'b0, 1'b1, 32'hC000_0000);
        idle("t3", 2);
        check_caps("t3", 2, 16'h7FFF, 1'b1, 16'h8000);

        // Gaps inside a window, then an abutting window
        step("t4", 1'b0, 1'b1, 32'h0001_0000);
        step("t4", 1'b0, 1'b0, 32'hDEAD_BEEF);
        step("t4", 1'b0, 1'b0, 32'hDEAD_BEEF);
        step("t4", 1'b0, 1'b1, 32'h0001_0000);
        step("t4", 1'b0, 1'b0, 32'h1234_5678);
        step("t4", 1'b0, 1'b1, 32'h0001_0000);
        for (int i = 0; i < 3; i++) step("t4b", 1'b0, 1'b1, 32'h0002_0000);
        idle("t4", 2);
        check_caps("t4", 2, 16'h0300, 1'b0, 16'h0600);

        // Clear mid-window
        step("t5", 1'b0, 1'b1, 32'h0005_0000);
        step("t5", 1'b0, 1'b1, 32'h0005_0000);
        step("t5.clr", 1'b1, 1'b1, 32'h0005_0000);
        for (int i = 0; i < 3; i++) step("t5", 1'b0, 1'b1, 32'h0001_0000);
        idle("t5", 2);
        check_caps("t5", 1, 16'h0300, 1'b0, 16'h0);

        // Clear right after a last tap drops that window
        for (int i = 0; i < 3; i++) step("t5d", 1'b0, 1'b1, 32'h0004_0000);
        step("t5d.clr", 1'b1, 1'b0, 32'h0);
        idle("t5d", 2);
        check_caps("t5d", 0, 16'h0, 1'b0, 16'h0);

        // Reset mid-window
        step("t5r", 1'b0, 1'b1, 32'h0007_0000);
        step("t5r", 1'b0, 1'b1, 32'h0007_0000);
        pulse_reset("t5r.rst");
        for (int i = 0; i < 3; i++) step("t5r", 1'b0, 1'b1, 32'h0001_0000);
        idle("t5r", 2);
        check_caps("t5r", 1, 16'h0300, 1'b0, 16'h0);

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            v = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 1) == 0)
                p = $urandom;
            else
                p = 32'($signed($urandom_range(0, 32'h0040_0000)) - 32'sh0020_0000);
            step("rand", c, v, p);
        end
        cap_res.delete();
        cap_ovf.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stalled simulation
    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
